// File: rtl/sdram_arb_pkg.sv
// Shared types and default geometry for the SDRAM frame-buffer arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  localparam int unsigned DEF_BURST_LEN    = 256;
  localparam int unsigned DEF_FRAME_WORDS  = 12800;
  localparam int unsigned BURSTS_PER_FRAME = DEF_FRAME_WORDS / DEF_BURST_LEN;

endpackage

// File: rtl/frame_ptr_ctr.sv
// Burst-granular frame pointer: restarts on start, advances one burst per step,
// wraps to zero at the end of the frame and drops its active flag there.
module frame_ptr_ctr
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr,
  output logic              active
);

  logic [ADDR_W-1:0] ptr_inc;

  always_comb ptr_inc = ptr + ADDR_W'(BURST_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      active <= 1'b0;
    end else if (start) begin
      ptr    <= '0;
      active <= 1'b1;
    end else if (step) begin
      if (ptr_inc == ADDR_W'(FRAME_WORDS)) begin
        ptr    <= '0;
        active <= 1'b0;
      end else begin
        ptr <= ptr_inc;
      end
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Shares one SDRAM burst port between camera writes and display reads over a
// two-bank ping-pong frame buffer.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 22,
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BANK_OFFSET = 22'h20000,
  parameter int unsigned       FIFO_DEPTH  = 1024,
  parameter int unsigned       RD_URGENT   = 128
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              cam_frame_start,
  input  logic              rd_frame_start,
  input  logic [10:0]       wr_fifo_level,
  input  logic [10:0]       rd_fifo_level,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  input  logic              cmd_done,
  output logic              rd_bank,
  output logic              frame_drop
);

  arb_state_t        state, state_nx;
  grant_t            grant, grant_nx;
  logic              grant_ok;
  logic              cam_pend, rd_pend, wr_bank, fresh;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, issue_addr;
  logic              wr_active, rd_active;
  logic              wr_req, rd_req, rd_urgent;
  logic              apply, cam_apply, rd_apply, drop, swap;
  logic              burst_done, wr_step, rd_step, fresh_set;

  always_comb begin
    wr_req    = wr_active && (wr_fifo_level >= 11'(BURST_LEN));
    rd_req    = rd_active && (rd_fifo_level <= 11'(FIFO_DEPTH - BURST_LEN));
    rd_urgent = rd_req && (rd_fifo_level < 11'(RD_URGENT));

    // Frame starts take a whole IDLE cycle; arbitration resumes next cycle
    // so it always sees the updated pointers and banks.
    apply     = (state == IDLE) && (cam_pend || rd_pend);
    cam_apply = apply && cam_pend;
    rd_apply  = apply && rd_pend;
    drop      = cam_apply && fresh;
    swap      = rd_apply && fresh && !cam_pend;

    burst_done = (state == BUSY) && cmd_done;
    wr_step    = burst_done && (grant == GRANT_WR);
    rd_step    = burst_done && (grant == GRANT_RD);
    fresh_set  = wr_step && (wr_ptr == ADDR_W'(FRAME_WORDS - BURST_LEN));
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    grant_ok = 1'b0;
    case (state)
      IDLE: begin
        if (!apply) begin
          if (rd_urgent) begin
            grant_nx = GRANT_RD;
            grant_ok = 1'b1;
          end else if (wr_req && rd_req) begin
            grant_nx = (grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
            grant_ok = 1'b1;
          end else if (wr_req) begin
            grant_nx = GRANT_WR;
            grant_ok = 1'b1;
          end else if (rd_req) begin
            grant_nx = GRANT_RD;
            grant_ok = 1'b1;
          end
        end
        if (grant_ok) state_nx = ISSUE;
      end
      ISSUE:   if (cmd_ready) state_nx = BUSY;
      BUSY:    if (cmd_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if (grant_nx == GRANT_WR)
      issue_addr = (wr_bank ? BANK_OFFSET : '0) + wr_ptr;
    else
      issue_addr = (rd_bank ? BANK_OFFSET : '0) + rd_ptr;
  end

  always_comb cmd_valid = (state == ISSUE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      grant      <= GRANT_RD;
      cmd_write  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      cam_pend   <= 1'b0;
      rd_pend    <= 1'b0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      fresh      <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      frame_drop <= drop;
      cam_pend   <= cam_frame_start || (cam_pend && !apply);
      rd_pend    <= rd_frame_start || (rd_pend && !apply);
      if (grant_ok) begin
        cmd_write <= (grant_nx == GRANT_WR);
        cmd_addr  <= issue_addr;
        cmd_len   <= 9'(BURST_LEN);
      end
      if (fresh_set)
        fresh <= 1'b1;
      else if (drop || swap)
        fresh <= 1'b0;
      if (swap) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
    end
  end

  frame_ptr_ctr #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_wr_ptr (
    .clk    (CLK),
    .rst_n  (RSTn),
    .start  (cam_apply),
    .step   (wr_step),
    .ptr    (wr_ptr),
    .active (wr_active)
  );

  frame_ptr_ctr #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_rd_ptr (
    .clk    (CLK),
    .rst_n  (RSTn),
    .start  (rd_apply),
    .step   (rd_step),
    .ptr    (rd_ptr),
    .active (rd_active)
  );

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Scoreboard bench: expected burst commands are queued from a frame-buffer
// model as stimulus is driven and popped when the arbiter issues a command.
module tb_sdram_frame_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        cam_frame_start, rd_frame_start;
  logic [10:0] wr_fifo_level, rd_fifo_level;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_done;
  logic [21:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        rd_bank, frame_drop;

  typedef struct {
    bit          write;
    logic [21:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  bit m_wr_bank, m_rd_bank, m_fresh;
  int m_wr_ptr, m_rd_ptr;

  always #5 CLK = ~CLK;

  sdram_frame_arbiter #(
    .ADDR_W      (22),
    .BURST_LEN   (256),
    .FRAME_WORDS (12800),
    .BANK_OFFSET (22'h20000),
    .FIFO_DEPTH  (1024),
    .RD_URGENT   (128)
  ) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .cam_frame_start (cam_frame_start),
    .rd_frame_start  (rd_frame_start),
    .wr_fifo_level   (wr_fifo_level),
    .rd_fifo_level   (rd_fifo_level),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_done        (cmd_done),
    .rd_bank         (rd_bank),
    .frame_drop      (frame_drop)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_burst(input bit w);
    exp_t e;
    e.write = w;
    if (w) begin
      e.addr   = 22'(m_wr_ptr) + (m_wr_bank ? 22'h20000 : 22'h0);
      m_wr_ptr += 256;
      if (m_wr_ptr == 12800) begin
        m_wr_ptr = 0;
        m_fresh  = 1'b1;
      end
    end else begin
      e.addr   = 22'(m_rd_ptr) + (m_rd_bank ? 22'h20000 : 22'h0);
      m_rd_ptr += 256;
      if (m_rd_ptr == 12800) m_rd_ptr = 0;
    end
    q.push_back(e);
  endtask

  task automatic m_cam_start(output bit drop);
    drop     = m_fresh;
    m_fresh  = 1'b0;
    m_wr_ptr = 0;
  endtask

  task automatic m_rd_start();
    m_rd_ptr = 0;
    if (m_fresh) begin
      m_rd_bank = m_wr_bank;
      m_wr_bank = ~m_wr_bank;
      m_fresh   = 1'b0;
    end
  endtask

  task automatic pulse_cam();
    @(negedge CLK) cam_frame_start = 1'b1;
    @(negedge CLK) cam_frame_start = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge CLK) rd_frame_start = 1'b1;
    @(negedge CLK) rd_frame_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk_eq({tag, "_valid"}, 32'(cmd_valid), 0);
    chk_eq({tag, "_write"}, 32'(cmd_write), 0);
    chk_eq({tag, "_addr"},  32'(cmd_addr),  0);
    chk_eq({tag, "_len"},   32'(cmd_len),   0);
    chk_eq({tag, "_rdbank"}, 32'(rd_bank),  0);
    chk_eq({tag, "_drop"},  32'(frame_drop), 0);
  endtask

  // Acts as the SDRAM controller for one command.
  task automatic serve(input int ready_delay, input bit rd_pulse_busy, input bit rst_busy);
    int   n = 0;
    exp_t e;
    @(negedge CLK);
    while (!cmd_valid && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_valid) begin
      chk_eq("cmd_timeout", 0, 1);
      if (q.size() > 0) void'(q.pop_front());
      return;
    end
    if (q.size() == 0) begin
      chk_eq("unexpected_cmd", 1, 0);
      return;
    end
    e = q.pop_front();
    chk_eq("cmd_write", 32'(cmd_write), 32'(e.write));
    chk_eq("cmd_addr",  32'(cmd_addr),  32'(e.addr));
    chk_eq("cmd_len",   32'(cmd_len),   256);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge CLK);
      chk_eq("hold_valid", 32'(cmd_valid), 1);
      chk_eq("hold_addr",  32'(cmd_addr),  32'(e.addr));
      chk_eq("hold_write", 32'(cmd_write), 32'(e.write));
    end
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
    chk_eq("valid_drop", 32'(cmd_valid), 0);
    if (rst_busy) begin
      #2 RSTn = 1'b0;
      #1 check_outputs_zero("async_rst");
      @(negedge CLK);
      RSTn = 1'b1;
      return;
    end
    if (rd_pulse_busy) begin
      rd_frame_start = 1'b1;
      @(negedge CLK);
      rd_frame_start = 1'b0;
    end
    @(negedge CLK);
    cmd_done = 1'b1;
    @(negedge CLK);
    cmd_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    bit drop;
    int seen;

    RSTn = 1'b0;
    cam_frame_start = 1'b0;
    rd_frame_start  = 1'b0;
    wr_fifo_level   = 11'd0;
    rd_fifo_level   = 11'd1000;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    m_wr_bank = 1'b0;
    m_rd_bank = 1'b0;
    m_fresh   = 1'b0;
    m_wr_ptr  = 0;
    m_rd_ptr  = 0;

    idle_cycles(3);
    check_outputs_zero("in_rst");
    RSTn = 1'b1;
    idle_cycles(3);
    check_outputs_zero("post_rst");

    // First camera frame fills bank 0.
    pulse_cam();
    m_cam_start(drop);
    wr_fifo_level = 11'd256;
    for (int i = 0; i < 50; i++) begin
      expect_burst(1'b1);
      serve(0, 1'b0, 1'b0);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (cmd_valid) seen++;
    end
    chk_eq("wr_frame_end_idle", 32'(seen), 0);
    wr_fifo_level = 11'd0;

    // Display start swaps banks; first read from bank 0.
    pulse_rd();
    m_rd_start();
    idle_cycles(3);
    chk_eq("rd_bank_after_swap", 32'(rd_bank), 32'(m_rd_bank));
    rd_fifo_level = 11'd500;
    expect_burst(1'b0);
    serve(0, 1'b0, 1'b0);
    rd_fifo_level = 11'd1000;

    // Camera now writes the other bank; both requesting alternates.
    pulse_cam();
    m_cam_start(drop);
    idle_cycles(3);
    wr_fifo_level = 11'd256;
    rd_fifo_level = 11'd500;
    expect_burst(1'b1);
    expect_burst(1'b0);
    expect_burst(1'b1);
    expect_burst(1'b0);
    repeat (4) serve(0, 1'b0, 1'b0);

    // Urgent display level forces reads every time.
    rd_fifo_level = 11'd100;
    for (int i = 0; i < 3; i++) begin
      expect_burst(1'b0);
      serve(0, 1'b0, 1'b0);
    end
    rd_fifo_level = 11'd1000;

    // Finish the bank-1 frame so it becomes fresh.
    for (int i = 0; i < 48; i++) begin
      expect_burst(1'b1);
      serve(0, 1'b0, 1'b0);
    end
    wr_fifo_level = 11'd0;
    idle_cycles(3);

    // New camera frame before display consumed the fresh one.
    pulse_cam();
    m_cam_start(drop);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (frame_drop) seen++;
    end
    chk_eq("frame_drop_pulses", 32'(seen), drop ? 1 : 0);
    chk_eq("rd_bank_no_swap", 32'(rd_bank), 32'(m_rd_bank));
    wr_fifo_level = 11'd256;
    expect_burst(1'b1);
    serve(0, 1'b0, 1'b0);
    wr_fifo_level = 11'd0;

    // Display start arriving mid-burst takes effect only afterwards.
    rd_fifo_level = 11'd500;
    expect_burst(1'b0);
    m_rd_start();
    serve(0, 1'b1, 1'b0);
    expect_burst(1'b0);
    serve(0, 1'b0, 1'b0);
    rd_fifo_level = 11'd1000;

    // Long cmd_ready stall, then reset during BUSY.
    wr_fifo_level = 11'd256;
    expect_burst(1'b1);
    serve(20, 1'b0, 1'b0);
    expect_burst(1'b1);
    serve(0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (cmd_valid) seen++;
    end
    chk_eq("post_abort_idle", 32'(seen), 0);
    chk_eq("queue_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
